c1_window_sched: RTL and testbench
==================================

# c1_window_sched

Sequencer for the C1 convolution window address generator. It runs one full window sweep of the 30x30 input map per output kernel and gates the generator's `en`/`pause` against downstream back-pressure. It also delays each window's kernel/window tags to line up with the anchor-ROM read latency. It sits between the layer controller (start/done) and the generator plus MAC array.

## Interface
- `H_IMAGE_LEN`, 30, image width
- `V_IMAGE_LEN`, 30, image height
- `H_WINDOW_LEN`, 5, window width
- `V_WINDOW_LEN`, 5, window height
- `N_KERNEL`, 6, output kernels per layer run (1..255)
- `ROM_LAT`, 1, anchor-ROM read latency in cycles (1..4)
- Derived `W = (H_IMAGE_LEN-H_WINDOW_LEN+1)*(V_IMAGE_LEN-V_WINDOW_LEN+1)`; 676 at defaults.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `start` in 1: begin a layer run; sampled only in IDLE.
- `abort` in 1: cancel the run; highest priority after reset.
- `out_ready` in 1: downstream MAC can accept issues.
- `agen_en` out 1: generator count enable.
- `agen_pause` out 1: generator hold (counter not cleared).
- `win_valid` out 1: a window address set is valid this cycle.
- `kernel_idx` out 8: kernel tag of the valid window.
- `win_idx` out 32: window index 0..W-1 of the valid window.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at run completion.
- `stall_cnt` out 32: see Configuration.

## Operation
- States:
  - IDLE: `agen_en=0`, `agen_pause=0`, so the generator counter clears or holds at 0.
  - RUN: issues windows.
  - STALL: holds the current position.
  - DRAIN: flushes the ROM pipeline.
  - DONE: one cycle.
- Internal counters `k` (kernel) and `w` (window, mirrors the generator counter), both 0 in IDLE.
- IDLE -> RUN when `start=1`. `start` is ignored in every other state.
- RUN, `out_ready=1`: issue cycle.
  - `agen_en=1`; tag `{k,w}` enters the ROM_LAT-deep delay line.
  - If `w=W-1`, then `w<=0`; the generator wraps itself at the same edge.
  - If also `k=N_KERNEL-1`, go to DRAIN; else `k<=k+1`.
  - Otherwise `w<=w+1`.
- RUN, `out_ready=0`: go to STALL. That cycle `agen_en=0`, `agen_pause=1`, no issue.
- STALL: `agen_en=0`, `agen_pause=1`. Return to RUN and issue in the first cycle `out_ready=1`; STALL is combinationally transparent to `out_ready`.
- DRAIN: `agen_en=0`, `agen_pause=0`. Lasts exactly ROM_LAT cycles, then DONE.
- DONE: `done=1` for one cycle, then IDLE.
- `win_valid`, `kernel_idx`, `win_idx` equal the issue flag and tag delayed by exactly ROM_LAT cycles. Tags read 0 when `win_valid=0`.
- Back-pressure: issues in flight when `out_ready` falls still emerge. Downstream must absorb up to ROM_LAT windows after deasserting `out_ready`.
- `abort=1` in any state:
  - Next cycle the block is IDLE; `k`, `w` and the delay line are cleared.
  - `win_valid` is 0 from the next cycle; no `done` pulse.
  - `agen_en=0` and `agen_pause=0`, so the generator counter clears.
- `abort` takes priority over `start` in the same cycle.

## Timing
- Reset (`rst_n=0` at an edge): IDLE, delay line cleared. Outputs: `agen_en=0`, `agen_pause=0`, `win_valid=0`, `kernel_idx=0`, `win_idx=0`, `busy=0`, `done=0`, `stall_cnt=0`. Reset mid-run behaves like `abort`.
- Cycle n means the cycle after edge n. Take `start` high before edge 0 with no stalls:
  - First issue in cycle 0.
  - Last issue in cycle `N_KERNEL*W-1`.
  - First `win_valid` in cycle ROM_LAT.
  - `done` in cycle `N_KERNEL*W+ROM_LAT`.
  - `busy` low from cycle `N_KERNEL*W+ROM_LAT+1`.
- Each STALL cycle adds exactly one cycle to the above.
- `win_idx` is the sequential window index. Address arithmetic stays in the generator; there is no wrap between kernels beyond `w` returning to 0.

## Configuration
- `C1_SCHED_PERF_EN` defined:
  - `stall_cnt` counts cycles spent in STALL plus RUN cycles with `out_ready=0`.
  - It saturates at 2^32-1 and clears on reset and on IDLE->RUN.
  - Its value is held after `done`.
- Undefined: `stall_cnt` is tied to 0 and no counter logic is compiled.

## Test plan
- Defaults, `out_ready=1`, start at edge 0:
  - 4056 `win_valid` pulses.
  - First carries `kernel_idx=0`, `win_idx=0` in cycle 1; last carries `kernel_idx=5`, `win_idx=675` in cycle 4056.
  - `done` in cycle 4057 only.
- Drop `out_ready` for 10 cycles at issue `w=100`, k=0:
  - The window with `w=100` is issued; the `out_ready=0` cycle and the next 9 are STALL.
  - `agen_pause=1`, `agen_en=0` for 10 cycles; `win_idx` continues 101 on resume with no gaps or duplicates.
  - `done` arrives 10 cycles late; with the macro, `stall_cnt=10`.
- Kernel boundary: issue sequence `(k=0,w=675)` then `(k=1,w=0)` on consecutive cycles; the generator wraps at the same edge.
- `abort` at issue `(k=3,w=200)`:
  - IDLE next cycle; `win_valid=0` from the next cycle, so the window issued in the abort cycle is dropped.
  - No `done`; a new `start` restarts from `(0,0)`.
- `start` pulsed during RUN: ignored, run unaffected. `start` and `abort` in the same IDLE cycle: stays IDLE.
- `ROM_LAT=3`, `N_KERNEL=1`:
  - First `win_valid` in cycle 3; `done` in cycle 679.
  - Deassert `out_ready` mid-run: exactly 3 in-flight windows still emerge.

Source files
------------

// File: rtl/c1_window_sched.sv
// c1_window_sched: sweeps every window of the input map once per kernel and gates the
// address generator against downstream back-pressure. Each issued tag {kernel, window}
// is delayed by ROM_LAT cycles so it lines up with the anchor-ROM read data.
// Ports: clk, rst_n (sync, active-low), start, abort, out_ready in;
//        agen_en, agen_pause, win_valid, kernel_idx[7:0], win_idx[31:0], busy, done,
//        stall_cnt[31:0] out.
// Option: C1_SCHED_PERF_EN compiles the back-pressure cycle counter behind stall_cnt.
module c1_window_sched #(
  parameter int H_IMAGE_LEN  = 30,
  parameter int V_IMAGE_LEN  = 30,
  parameter int H_WINDOW_LEN = 5,
  parameter int V_WINDOW_LEN = 5,
  parameter int N_KERNEL     = 6,
  parameter int ROM_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        out_ready,
  output logic        agen_en,
  output logic        agen_pause,
  output logic        win_valid,
  output logic [7:0]  kernel_idx,
  output logic [31:0] win_idx,
  output logic        busy,
  output logic        done,
  output logic [31:0] stall_cnt
);
  localparam int W = (H_IMAGE_LEN - H_WINDOW_LEN + 1) * (V_IMAGE_LEN - V_WINDOW_LEN + 1);
  typedef enum logic [2:0] {IDLE, RUN, STALL, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [7:0] k;
  logic [31:0] w;
  logic [2:0] dcnt;
  logic active, last_w, last_k;
  logic [40:0] dl [ROM_LAT];
  // STALL is transparent to out_ready, so RUN and STALL share the same issue gating
  assign active = state == RUN || state == STALL;
  assign agen_en = active && out_ready;
  assign agen_pause = active && !out_ready;
  assign last_w = w == 32'(W - 1);
  assign last_k = k == 8'(N_KERNEL - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign {win_valid, kernel_idx, win_idx} = dl[ROM_LAT-1];
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = start ? RUN : IDLE;
      RUN, STALL: state_n = !out_ready ? STALL : (last_w && last_k) ? DRAIN : RUN;
      DRAIN:      state_n = dcnt == 3'(ROM_LAT - 1) ? DONE : DRAIN;
      default:    state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  // non-issue slots push zeros so the tags read 0 whenever win_valid is low
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      k <= '0;
      w <= '0;
      dcnt <= '0;
      for (int i = 0; i < ROM_LAT; i++) dl[i] <= '0;
    end else begin
      if (agen_en) begin
        w <= last_w ? '0 : w + 32'd1;
        if (last_w) k <= last_k ? '0 : k + 8'd1;
      end
      dcnt <= state == DRAIN ? dcnt + 3'd1 : '0;
      dl[0] <= agen_en ? {1'b1, k, w} : '0;
      for (int i = 1; i < ROM_LAT; i++) dl[i] <= dl[i-1];
    end
  end
`ifdef C1_SCHED_PERF_EN
  logic [31:0] sc;
  // a STALL cycle that sees out_ready=1 is an issue cycle, so only paused cycles count
  always_ff @(posedge clk)
    if (!rst_n || (state == IDLE && start && !abort)) sc <= '0;
    else if (agen_pause && sc != '1) sc <= sc + 32'd1;
  assign stall_cnt = sc;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_c1_window_sched.sv
// tb_c1_window_sched: directed bench for c1_window_sched (default build and ROM_LAT=3/N_KERNEL=1)
module tb_c1_window_sched;
  logic clk = 0;
  logic rst_n, start, abort, out_ready, sel;
  logic en_a, pause_a, wv_a, busy_a, done_a, en_b, pause_b, wv_b, busy_b, done_b;
  logic [7:0] k_a, k_b;
  logic [31:0] w_a, w_b, sc_a, sc_b;
  logic g_en, g_pause, g_wv, g_busy, g_done;
  logic [7:0] g_k;
  logic [31:0] g_w, g_sc;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  c1_window_sched dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out_ready(out_ready),
    .agen_en(en_a), .agen_pause(pause_a), .win_valid(wv_a), .kernel_idx(k_a),
    .win_idx(w_a), .busy(busy_a), .done(done_a), .stall_cnt(sc_a)
  );
  c1_window_sched #(.N_KERNEL(1), .ROM_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out_ready(out_ready),
    .agen_en(en_b), .agen_pause(pause_b), .win_valid(wv_b), .kernel_idx(k_b),
    .win_idx(w_b), .busy(busy_b), .done(done_b), .stall_cnt(sc_b)
  );
  assign g_en = sel ? en_b : en_a;
  assign g_pause = sel ? pause_b : pause_a;
  assign g_wv = sel ? wv_b : wv_a;
  assign g_busy = sel ? busy_b : busy_a;
  assign g_done = sel ? done_b : done_a;
  assign g_k = sel ? k_b : k_a;
  assign g_w = sel ? w_b : w_a;
  assign g_sc = sel ? sc_b : sc_a;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  // start at edge 0, out_ready low over cycles st_lo..st_hi, start pulsed in st_pulse,
  // abort in ab_cyc (negative disables)
  task automatic run(input bit s, input int nk, input int lat, input int st_lo, input int st_hi,
                     input int st_pulse, input int ab_cyc);
    int nw, stl, done_exp, last_n, pulses, first_cyc, seq_err, tag_err, done_n, done_cyc;
    int pause_n, en_n, inflight, ek, ew, lk, lw, busy_dn, busy_end, kb0, kb1, stc_exp;
    int ab_wv, ab_busy, ab_en;
    nw = 676 * nk;
    stl = st_hi >= st_lo ? st_hi - st_lo + 1 : 0;
    done_exp = nw + lat + stl;
    last_n = ab_cyc >= 0 ? ab_cyc + 20 : done_exp + 3;
    {pulses, first_cyc, seq_err, tag_err, done_n, done_cyc, pause_n, en_n, inflight} = '0;
    {ek, ew, lk, lw, busy_dn, busy_end, kb0, kb1, ab_wv, ab_busy, ab_en} = '0;
    first_cyc = -1;
    sel = s;
    start = 1;
    for (int n = 0; n <= last_n; n++) begin
      @(posedge clk);
      #1;
      start = n == st_pulse;
      out_ready = !(n >= st_lo && n <= st_hi);
      abort = n == ab_cyc;
      #1;
      if (g_wv) begin
        pulses++;
        if (first_cyc < 0) first_cyc = n;
        if (g_k != 8'(ek) || g_w != 32'(ew)) seq_err++;
        lk = int'(g_k);
        lw = int'(g_w);
        ew++;
        if (ew == 676) begin
          ew = 0;
          ek++;
        end
        if (n >= st_lo && n <= st_hi) inflight++;
      end else if (g_k != 0 || g_w != 0) tag_err++;
      if (g_done) begin
        done_n++;
        done_cyc = n;
      end
      if (g_pause) pause_n++;
      if (g_en) en_n++;
      if (n == done_exp) busy_dn = int'(g_busy);
      if (n == done_exp + 1) busy_end = int'(g_busy);
      if (n == lat + 675) kb0 = g_wv ? int'(g_k) * 1000 + int'(g_w) : -1;
      if (n == lat + 676) kb1 = g_wv ? int'(g_k) * 1000 + int'(g_w) : -1;
      if (n == ab_cyc + 1) begin
        ab_wv = int'(g_wv);
        ab_busy = int'(g_busy);
        ab_en = int'(g_en) + int'(g_pause);
      end
    end
    start = 0;
    abort = 0;
    out_ready = 1;
    chk("first_valid_cycle", first_cyc, lat);
    chk("sequence_errors", seq_err, 0);
    chk("idle_tags_nonzero", tag_err, 0);
    chk("pause_cycles", pause_n, stl);
    if (ab_cyc >= 0) begin
      chk("abort_pulses", pulses, ab_cyc - lat + 1);
      chk("abort_no_done", done_n, 0);
      chk("abort_wv_next", ab_wv, 0);
      chk("abort_busy_next", ab_busy, 0);
      chk("abort_en_pause_next", ab_en, 0);
    end else begin
      chk("valid_pulses", pulses, nw);
      chk("issue_cycles", en_n, nw);
      chk("done_count", done_n, 1);
      chk("done_cycle", done_cyc, done_exp);
      chk("busy_at_done", busy_dn, 1);
      chk("busy_after_done", busy_end, 0);
      chk("last_kernel", lk, nk - 1);
      chk("last_window", lw, 675);
`ifdef C1_SCHED_PERF_EN
      stc_exp = stl;
`else
      stc_exp = 0;
`endif
      chk("stall_cnt", g_sc, 32'(stc_exp));
      if (stl > 0) chk("inflight_after_drop", inflight, stl < lat ? stl : lat);
    end
    if (nk > 1 && st_lo < 0) begin
      chk("kernel_boundary_last", kb0, 675);
      chk("kernel_boundary_first", kb1, 1000);
    end
  endtask
  initial begin
    rst_n = 0;
    start = 0;
    abort = 0;
    out_ready = 1;
    sel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", {31'd0, en_a}, 0);
    chk("rst_pause", {31'd0, pause_a}, 0);
    chk("rst_valid", {31'd0, wv_a}, 0);
    chk("rst_kernel", {24'd0, k_a}, 0);
    chk("rst_window", w_a, 0);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_done", {31'd0, done_a}, 0);
    chk("rst_stall_cnt", sc_a, 0);
    chk("rst_busy_b", {31'd0, busy_b}, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    run(0, 6, 1, -1, -2, 500, -1);
    run(0, 6, 1, -1, -2, -1, 2228);
    run(0, 6, 1, 101, 110, -1, -1);
    start = 1;
    abort = 1;
    @(posedge clk);
    #1;
    start = 0;
    abort = 0;
    #1;
    chk("start_abort_busy_a", {31'd0, busy_a}, 0);
    chk("start_abort_busy_b", {31'd0, busy_b}, 0);
    @(posedge clk);
    #1;
    run(1, 1, 3, 300, 304, -1, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
